// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Turns the four raw push-buttons (Up, Down, Left, Right) into clean
//   signals for the stack calculator controller. Each button passes through
//   three stages: a two-flop synchroniser, a counter debounce and a small
//   FSM. The FSM emits one press strobe per accepted press. If the button's
//   bit is set in REPEAT_MASK, it keeps emitting repeat strobes for as long
//   as the button is held.
//
// Ports
//   i_clk          system clock, single domain
//   i_rst_n        asynchronous active-low reset
//   i_btn_raw      [3:0] raw buttons (bit0 Up, bit1 Down, bit2 Left,
//                  bit3 Right), asynchronous to i_clk
//   o_btn_level    [3:0] debounced, registered level
//   o_btn_pulse    [3:0] one-cycle press strobe, including repeat strobes
//   o_btn_release  [3:0] one-cycle release strobe
//
// Per-button FSM
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | released, or held with auto-repeat disabled
//   ST_DELAY  | held; counting toward the first repeat strobe
//   ST_REPEAT | held; emitting a repeat strobe every REPEAT_PERIOD cycles
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int         DB_CYCLES     = 1000000,
  parameter logic [3:0] REPEAT_MASK   = 4'b0000,
  parameter int         REPEAT_DELAY  = 50000000,
  parameter int         REPEAT_PERIOD = 10000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_btn_raw,
  output logic [3:0] o_btn_level,
  output logic [3:0] o_btn_pulse,
  output logic [3:0] o_btn_release
);

  localparam int CW   = $clog2(DB_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic [CW-1:0] r_db_cnt;
    logic          r_level;
    logic          w_accept;
    logic          w_rise;
    logic          w_fall;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          r_pulse;
    logic          r_release;
    logic          w_pulse_nxt;
    logic          w_release_nxt;

    // The level flips on the same edge that the counter hits its terminal
    // value. The FSM acts on that same edge, so the strobes line up with
    // the level change.
    assign w_accept = (r_sync2[gi] != r_level) && (r_db_cnt == CW'(DB_CYCLES - 1));
    assign w_rise   = w_accept &  r_sync2[gi];
    assign w_fall   = w_accept & ~r_sync2[gi];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_db_cnt <= '0;
        r_level  <= 1'b0;
      end else if (r_sync2[gi] == r_level) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_db_cnt <= '0;
        r_level  <= r_sync2[gi];
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state   <= ST_IDLE;
        r_timer   <= '0;
        r_pulse   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_timer   <= w_timer_nxt;
        r_pulse   <= w_pulse_nxt;
        r_release <= w_release_nxt;
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_pulse_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      // A release wins over a repeat that would land on the same edge, so
      // the two strobes for one bit can never be high together.
      if (w_fall) begin
        w_release_nxt = 1'b1;
        w_state_nxt   = ST_IDLE;
        w_timer_nxt   = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              w_pulse_nxt = 1'b1;
              w_timer_nxt = '0;
              if (REPEAT_MASK[gi]) w_state_nxt = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (r_timer == TW'(REPEAT_DELAY - 1)) begin
              w_pulse_nxt = 1'b1;
              w_timer_nxt = '0;
              w_state_nxt = ST_REPEAT;
            end else begin
              w_timer_nxt = r_timer + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_timer == TW'(REPEAT_PERIOD - 1)) begin
              w_pulse_nxt = 1'b1;
              w_timer_nxt = '0;
            end else begin
              w_timer_nxt = r_timer + 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
          end
        endcase
      end
    end

    assign o_btn_level[gi]   = r_level;
    assign o_btn_pulse[gi]   = r_pulse;
    assign o_btn_release[gi] = r_release;
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic [3:0] btn_release;

  int n_pass;
  int n_total;

  button_conditioner #(
    .DB_CYCLES    (4),
    .REPEAT_MASK  (4'b0011),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_btn_raw    (btn_raw),
    .o_btn_level  (btn_level),
    .o_btn_pulse  (btn_pulse),
    .o_btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic idle(input int n);
    @(negedge clk);
    btn_raw = 4'h0;
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    btn_raw = 4'hF;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({btn_level, btn_pulse, btn_release} !== 12'h000)
      $display("FAIL reset_async: got %h want 000", {btn_level, btn_pulse, btn_release});
    else n_pass++;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n_total++;
      if ({btn_level, btn_pulse, btn_release} !== 12'h000)
        $display("FAIL reset_hold k=%0d: got %h want 000", k, {btn_level, btn_pulse, btn_release});
      else n_pass++;
    end
    @(negedge clk);
    btn_raw = 4'h0;
    rst_n   = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  // Raw high for sampling edges 0..19, low from edge 20.
  task automatic test_clean_press();
    logic [3:0] exp_l, exp_p, exp_r;
    @(negedge clk);
    btn_raw = 4'b0100;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk); #1;
      exp_l = (k >= 5 && k < 25) ? 4'b0100 : 4'b0000;
      exp_p = (k == 5)  ? 4'b0100 : 4'b0000;
      exp_r = (k == 25) ? 4'b0100 : 4'b0000;
      n_total++;
      if ({btn_level, btn_pulse, btn_release} !== {exp_l, exp_p, exp_r})
        $display("FAIL clean_press k=%0d: got lvl=%b pul=%b rel=%b want lvl=%b pul=%b rel=%b",
                 k, btn_level, btn_pulse, btn_release, exp_l, exp_p, exp_r);
      else n_pass++;
      if (k == 19) btn_raw = 4'b0000;
    end
    idle(4);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    btn_raw = 4'b1000;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk); #1;
      n_total++;
      if ({btn_level, btn_pulse, btn_release} !== 12'h000)
        $display("FAIL glitch k=%0d: got %h want 000", k, {btn_level, btn_pulse, btn_release});
      else n_pass++;
      if (k == 2) btn_raw = 4'b0000;
    end
    idle(4);
  endtask

  // Raw high for edges 0..27; the level falls at edge 33, the same edge a
  // repeat would otherwise land on, so only the release may appear there.
  task automatic test_auto_repeat();
    logic [3:0] exp_l, exp_p, exp_r;
    @(negedge clk);
    btn_raw = 4'b0001;
    for (int k = 0; k <= 38; k++) begin
      @(posedge clk); #1;
      exp_l = (k >= 5 && k < 33) ? 4'b0001 : 4'b0000;
      exp_p = (k == 5 || k == 15 || k == 18 || k == 21 || k == 24 || k == 27 || k == 30)
              ? 4'b0001 : 4'b0000;
      exp_r = (k == 33) ? 4'b0001 : 4'b0000;
      n_total++;
      if ({btn_level, btn_pulse, btn_release} !== {exp_l, exp_p, exp_r})
        $display("FAIL auto_repeat k=%0d: got lvl=%b pul=%b rel=%b want lvl=%b pul=%b rel=%b",
                 k, btn_level, btn_pulse, btn_release, exp_l, exp_p, exp_r);
      else n_pass++;
      if (k == 27) btn_raw = 4'b0000;
    end
    idle(4);
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_l, exp_p, exp_r;
    @(negedge clk);
    btn_raw = 4'b1001;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1;
      exp_l = (k >= 5 && k < 11) ? 4'b1001 : 4'b0000;
      exp_p = (k == 5)  ? 4'b1001 : 4'b0000;
      exp_r = (k == 11) ? 4'b1001 : 4'b0000;
      n_total++;
      if ({btn_level, btn_pulse, btn_release} !== {exp_l, exp_p, exp_r})
        $display("FAIL simultaneous k=%0d: got lvl=%b pul=%b rel=%b want lvl=%b pul=%b rel=%b",
                 k, btn_level, btn_pulse, btn_release, exp_l, exp_p, exp_r);
      else n_pass++;
      if (k == 5) btn_raw = 4'b0000;
    end
    idle(4);
  endtask

  task automatic test_reset_mid_repeat();
    logic [3:0] exp_l, exp_p;
    @(negedge clk);
    btn_raw = 4'b0010;
    for (int k = 0; k <= 18; k++) begin
      @(posedge clk); #1;
      exp_l = (k >= 5) ? 4'b0010 : 4'b0000;
      exp_p = (k == 5 || k == 15 || k == 18) ? 4'b0010 : 4'b0000;
      n_total++;
      if ({btn_level, btn_pulse, btn_release} !== {exp_l, exp_p, 4'b0000})
        $display("FAIL pre_reset k=%0d: got lvl=%b pul=%b rel=%b want lvl=%b pul=%b rel=0000",
                 k, btn_level, btn_pulse, btn_release, exp_l, exp_p);
      else n_pass++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({btn_level, btn_pulse, btn_release} !== 12'h000)
      $display("FAIL mid_reset_async: got %h want 000", {btn_level, btn_pulse, btn_release});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_total++;
      if ({btn_level, btn_pulse, btn_release} !== 12'h000)
        $display("FAIL mid_reset_hold k=%0d: got %h want 000", k, {btn_level, btn_pulse, btn_release});
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      @(posedge clk); #1;
      exp_l = (k >= 5) ? 4'b0010 : 4'b0000;
      exp_p = (k == 5 || k == 15 || k == 18 || k == 21) ? 4'b0010 : 4'b0000;
      n_total++;
      if ({btn_level, btn_pulse, btn_release} !== {exp_l, exp_p, 4'b0000})
        $display("FAIL post_reset k=%0d: got lvl=%b pul=%b rel=%b want lvl=%b pul=%b rel=0000",
                 k, btn_level, btn_pulse, btn_release, exp_l, exp_p);
      else n_pass++;
    end
    idle(8);
    n_total++;
    if ({btn_level, btn_pulse, btn_release} !== 12'h000)
      $display("FAIL post_reset_idle: got %h want 000", {btn_level, btn_pulse, btn_release});
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b1;
    btn_raw = 4'h0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
